// File: rtl/cfg_bank_pkg.sv
// Shared constants, region typing and address decode for the configuration register bank.
package cfg_bank_pkg;

  localparam logic [7:0] DefaultBaseAddr = 8'h40;

  localparam int unsigned IDX_PWM_PERIOD_H = 0;
  localparam int unsigned IDX_PERIOD_REF_H = 2;
  localparam int unsigned IDX_KP           = 4;
  localparam int unsigned IDX_KI           = 5;
  localparam int unsigned IDX_KDOVR        = 6;

  typedef enum logic [1:0] {
    RegionNone,
    RegionPair,
    RegionRw,
    RegionRo
  } region_e;

  typedef struct packed {
    logic [7:0] idx;
    logic       in_range;
    region_e    region;
  } decode_t;

  // The addr >= base_addr term rejects addresses whose subtraction would wrap.
  function automatic decode_t cfg_decode(input logic [7:0]  addr,
                                         input logic [7:0]  base_addr,
                                         input int unsigned depth,
                                         input int unsigned num_ro,
                                         input int unsigned num_pairs);
    decode_t     d;
    int unsigned idx_u;
    d.idx      = addr - base_addr;
    idx_u      = 32'(d.idx);
    d.in_range = (addr >= base_addr) && (idx_u < depth);
    if (!d.in_range) begin
      d.region = RegionNone;
    end else if (idx_u < 2 * num_pairs) begin
      d.region = RegionPair;
    end else if (idx_u < depth - num_ro) begin
      d.region = RegionRw;
    end else begin
      d.region = RegionRo;
    end
    return d;
  endfunction

endpackage

// File: rtl/cfg_register_bank_if.sv
// Host byte-bus between the address decoder and the configuration register bank.
interface cfg_register_bank_if;

  logic       wr_en;
  logic       rd_en;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       lock;
  logic [7:0] rdata;
  logic       rd_valid;
  logic       addr_err;

  modport master (
    output wr_en, rd_en, addr, wdata, lock,
    input  rdata, rd_valid, addr_err
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata, lock,
    output rdata, rd_valid, addr_err
  );

endinterface

// File: rtl/cfg_pair_stager.sv
// Holds the high byte of one 16-bit pair until the low-byte write commits both halves.
module cfg_pair_stager (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_i,
  input  logic       odd_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] stage_o,
  output logic       commit_o
);

  logic [7:0] stage_q, stage_d;

  // Staging survives a commit so later low-byte writes reuse the last high byte.
  always_comb begin
    stage_d = stage_q;
    if (wr_i && !odd_i) begin
      stage_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= 8'h00;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o  = stage_q;
  assign commit_o = wr_i && odd_i;

endmodule

// File: rtl/cfg_register_bank.sv
// Host-facing configuration bank: RW config bytes, atomic pairs, RO status, registered reads.
module cfg_register_bank
  import cfg_bank_pkg::*;
#(
  parameter int unsigned                  DEPTH       = 32,
  parameter int unsigned                  NUM_RO      = 4,
  parameter int unsigned                  NUM_PAIRS   = 2,
  parameter logic [7:0]                   BASE_ADDR   = DefaultBaseAddr,
  parameter logic [(DEPTH-NUM_RO)*8-1:0]  RESET_IMAGE = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cfg_register_bank_if.slave            bus,
  input  logic [NUM_RO*8-1:0]           status_in,
  output logic                          cfg_update,
  output logic [(DEPTH-NUM_RO)*8-1:0]   cfg_flat
);

  localparam int unsigned NumRw = DEPTH - NUM_RO;

  decode_t              dec;
  logic                 wr_ok;
  logic [NUM_PAIRS-1:0] pair_wr;
  logic [NUM_PAIRS-1:0] pair_commit;
  logic [7:0]           pair_stage [NUM_PAIRS];

  logic [7:0] rw_q [NumRw];
  logic [7:0] rw_d [NumRw];
  logic [7:0] rdata_q, rdata_d;
  logic       rd_valid_q;
  logic       addr_err_q, addr_err_d;
  logic       cfg_update_q, cfg_update_d;

  assign dec   = cfg_decode(bus.addr, BASE_ADDR, DEPTH, NUM_RO, NUM_PAIRS);
  assign wr_ok = bus.wr_en && dec.in_range && !bus.lock && (dec.region != RegionRo);

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    assign pair_wr[p] = wr_ok && (dec.region == RegionPair) && (dec.idx[7:1] == 7'(p));

    cfg_pair_stager u_stager (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_i     (pair_wr[p]),
      .odd_i    (dec.idx[0]),
      .wdata_i  (bus.wdata),
      .stage_o  (pair_stage[p]),
      .commit_o (pair_commit[p])
    );
  end

  always_comb begin
    rw_d         = rw_q;
    cfg_update_d = 1'b0;
    if (wr_ok && (dec.region == RegionRw)) begin
      for (int k = 0; k < NumRw; k++) begin
        if (dec.idx == 8'(k)) begin
          rw_d[k]      = bus.wdata;
          cfg_update_d = 1'b1;
        end
      end
    end
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (pair_commit[p]) begin
        rw_d[2*p]    = pair_stage[p];
        rw_d[2*p+1]  = bus.wdata;
        cfg_update_d = 1'b1;
      end
    end
  end

  // Reads see pre-edge register contents, so a colliding write is not visible yet.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.rd_en) begin
      rdata_d = 8'h00;
      if ((dec.region == RegionRw) || (dec.region == RegionPair)) begin
        for (int k = 0; k < NumRw; k++) begin
          if (dec.idx == 8'(k)) begin
            rdata_d = rw_q[k];
          end
        end
      end else if (dec.region == RegionRo) begin
        for (int k = 0; k < NUM_RO; k++) begin
          if (dec.idx == 8'(NumRw + k)) begin
            rdata_d = status_in[8*k +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    addr_err_d = ((bus.rd_en || bus.wr_en) && !dec.in_range) ||
                 (bus.wr_en && (bus.lock || (dec.region == RegionRo)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NumRw; k++) begin
        rw_q[k] <= RESET_IMAGE[8*k +: 8];
      end
      rdata_q      <= 8'h00;
      rd_valid_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      cfg_update_q <= 1'b0;
    end else begin
      rw_q         <= rw_d;
      rdata_q      <= rdata_d;
      rd_valid_q   <= bus.rd_en;
      addr_err_q   <= addr_err_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  always_comb begin
    cfg_flat = '0;
    for (int k = 0; k < NumRw; k++) begin
      cfg_flat[8*k +: 8] = rw_q[k];
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_err = addr_err_q;
  assign cfg_update   = cfg_update_q;

endmodule

// File: tb/tb_cfg_register_bank.sv
// Directed plus randomized bench for cfg_register_bank against a byte-array reference model.
module tb_cfg_register_bank;
  import cfg_bank_pkg::*;

  localparam int Depth = 32;
  localparam int NumRo = 4;
  localparam int NumRw = Depth - NumRo;
  localparam int Base  = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  status;
  logic         cfg_update, cfg_update2;
  logic [223:0] cfg_flat, cfg_flat2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_rw [NumRw];
  logic [7:0] m_stage [2];
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  cfg_register_bank_if bus ();
  cfg_register_bank_if bus2 ();

  cfg_register_bank u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .status_in  (status),
    .cfg_update (cfg_update),
    .cfg_flat   (cfg_flat)
  );

  cfg_register_bank #(
    .RESET_IMAGE (224'hA5)
  ) u_dut_img (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus2),
    .status_in  (32'h0),
    .cfg_update (cfg_update2),
    .cfg_flat   (cfg_flat2)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NumRw; k++) m_rw[k] = 8'h00;
    m_stage[0] = 8'h00;
    m_stage[1] = 8'h00;
    m_rdata    = 8'h00;
  endtask

  function automatic logic [223:0] model_flat();
    logic [223:0] f;
    for (int k = 0; k < NumRw; k++) f[8*k +: 8] = m_rw[k];
    return f;
  endfunction

  // One bus cycle on the main DUT, then compare every output with the model.
  task automatic op(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] wd,
                    input logic lk);
    int   idx;
    bit   in_r;
    logic e_err, e_upd;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.addr  = a;
    bus.wdata = wd;
    bus.lock  = lk;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    idx  = int'(a) - Base;
    in_r = (idx >= 0) && (idx < Depth);
    e_err = 1'b0;
    if ((wr || rd) && !in_r) e_err = 1'b1;
    if (wr && lk) e_err = 1'b1;
    if (wr && in_r && idx >= NumRw) e_err = 1'b1;
    if (rd) begin
      if (!in_r) m_rdata = 8'h00;
      else if (idx < NumRw) m_rdata = m_rw[idx];
      else m_rdata = status[8*(idx-NumRw) +: 8];
    end
    e_upd = 1'b0;
    if (wr && in_r && !lk && idx < NumRw) begin
      if (idx < 4) begin
        if (idx % 2 == 0) begin
          m_stage[idx/2] = wd;
        end else begin
          m_rw[idx-1] = m_stage[idx/2];
          m_rw[idx]   = wd;
          e_upd       = 1'b1;
        end
      end else begin
        m_rw[idx] = wd;
        e_upd     = 1'b1;
      end
    end

    check($sformatf("rdata@%0h", a), 256'(bus.rdata), 256'(m_rdata));
    check($sformatf("rd_valid@%0h", a), 256'(bus.rd_valid), 256'(rd));
    check($sformatf("addr_err@%0h", a), 256'(bus.addr_err), 256'(e_err));
    check($sformatf("cfg_update@%0h", a), 256'(cfg_update), 256'(e_upd));
    check($sformatf("cfg_flat@%0h", a), 256'(cfg_flat), 256'(model_flat()));
  endtask

  initial begin
    logic [15:0] prev_pair;
    logic [7:0]  ra, rw_b;
    logic        rwr, rrd, rlk;

    rst_n      = 1'b0;
    status     = 32'h0;
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
    bus.addr   = 8'h00;
    bus.wdata  = 8'h00;
    bus.lock   = 1'b0;
    bus2.wr_en = 1'b0;
    bus2.rd_en = 1'b0;
    bus2.addr  = 8'h00;
    bus2.wdata = 8'h00;
    bus2.lock  = 1'b0;
    model_reset();

    #12;
    check("reset_rdata", 256'(bus.rdata), 256'(8'h00));
    check("reset_rd_valid", 256'(bus.rd_valid), 256'(1'b0));
    check("reset_addr_err", 256'(bus.addr_err), 256'(1'b0));
    check("reset_cfg_update", 256'(cfg_update), 256'(1'b0));
    check("reset_cfg_flat", 256'(cfg_flat), 256'(224'h0));
    check("reset_img_byte0", 256'(cfg_flat2[7:0]), 256'(8'hA5));
    #1 rst_n = 1'b1;

    // First read after reset, then rd_valid must drop after one cycle.
    op(1'b0, 1'b1, 8'h40, 8'h00, 1'b0);
    check("first_read_data", 256'(bus.rdata), 256'(8'h00));
    check("first_read_valid", 256'(bus.rd_valid), 256'(1'b1));
    op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    bus2.rd_en = 1'b1;
    bus2.addr  = 8'h40;
    @(posedge clk);
    #1;
    bus2.rd_en = 1'b0;
    check("img_read_data", 256'(bus2.rdata), 256'(8'hA5));
    check("img_read_valid", 256'(bus2.rd_valid), 256'(1'b1));
    check("img_no_update", 256'(cfg_update2), 256'(1'b0));

    // Atomic pair 0.
    prev_pair = cfg_flat[15:0];
    op(1'b1, 1'b0, 8'h40, 8'h12, 1'b0);
    check("pair_hi_hidden", 256'(cfg_flat[15:0]), 256'(prev_pair));
    op(1'b1, 1'b0, 8'h41, 8'h34, 1'b0);
    check("pair_byte0", 256'(cfg_flat[7:0]), 256'(8'h12));
    check("pair_byte1", 256'(cfg_flat[15:8]), 256'(8'h34));
    check("pair_update", 256'(cfg_update), 256'(1'b1));
    op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    op(1'b0, 1'b1, 8'h40, 8'h00, 1'b0);
    check("pair_readback", 256'(bus.rdata), 256'(8'h12));

    // Read-only status region.
    status = 32'h0000_005A;
    op(1'b0, 1'b1, 8'(Base + NumRw), 8'h00, 1'b0);
    check("ro_read", 256'(bus.rdata), 256'(8'h5A));
    op(1'b1, 1'b0, 8'(Base + NumRw), 8'hFF, 1'b0);
    check("ro_write_err", 256'(bus.addr_err), 256'(1'b1));
    op(1'b0, 1'b1, 8'(Base + NumRw), 8'h00, 1'b0);
    check("ro_reread", 256'(bus.rdata), 256'(8'h5A));

    // Range and lock.
    op(1'b0, 1'b1, 8'h3F, 8'h00, 1'b0);
    check("below_base_data", 256'(bus.rdata), 256'(8'h00));
    check("below_base_err", 256'(bus.addr_err), 256'(1'b1));
    op(1'b0, 1'b1, 8'(Base + Depth), 8'h00, 1'b0);
    check("above_top_err", 256'(bus.addr_err), 256'(1'b1));
    op(1'b1, 1'b0, 8'(Base + IDX_KP), 8'h07, 1'b1);
    check("lock_err", 256'(bus.addr_err), 256'(1'b1));
    check("lock_no_update", 256'(cfg_update), 256'(1'b0));
    check("lock_reg4", 256'(cfg_flat[39:32]), 256'(8'h00));

    // Read/write collision on Ki.
    op(1'b1, 1'b0, 8'(Base + IDX_KI), 8'h10, 1'b0);
    op(1'b1, 1'b1, 8'(Base + IDX_KI), 8'h20, 1'b0);
    check("collide_old", 256'(bus.rdata), 256'(8'h10));
    op(1'b0, 1'b1, 8'(Base + IDX_KI), 8'h00, 1'b0);
    check("collide_new", 256'(bus.rdata), 256'(8'h20));

    // Asynchronous reset between the two halves of pair 1.
    op(1'b1, 1'b0, 8'h42, 8'hAB, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_flat_clear", 256'(cfg_flat), 256'(224'h0));
    check("async_rdata_clear", 256'(bus.rdata), 256'(8'h00));
    #1 rst_n = 1'b1;
    model_reset();
    op(1'b1, 1'b0, 8'h43, 8'hCD, 1'b0);
    check("async_pair_hi", 256'(cfg_flat[23:16]), 256'(8'h00));
    check("async_pair_lo", 256'(cfg_flat[31:24]), 256'(8'hCD));

    // Randomized traffic around and across the whole address window.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) ra = 8'($urandom_range(8'h40, 8'h43));
      else ra = 8'($urandom_range(8'h38, 8'h67));
      rw_b = 8'($urandom);
      rwr  = 1'($urandom_range(0, 1));
      rrd  = 1'($urandom_range(0, 1));
      rlk  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) status = $urandom;
      op(rwr, rrd, ra, rw_b, rlk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
